// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the control inputs (start, redirect, ready), the program-memory
// read path (Fetch_Address_o -> Instruction_i) and the IF/ID outputs.
//   slave  : the fetch unit (consumes *_i, drives *_o)
//   master : the environment (drives *_i, observes *_o)
interface instruction_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start_i;
  logic                  Redirect_i;
  logic [DATA_WIDTH-1:0] Redirect_Target_i;
  logic [DATA_WIDTH-1:0] Instruction_i;
  logic                  Ready_i;
  logic [DATA_WIDTH-1:0] Fetch_Address_o;
  logic [DATA_WIDTH-1:0] Instruction_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] PC_Plus4_o;
  logic                  Valid_o;
  logic                  Error_o;
  logic [DATA_WIDTH-1:0] Fetch_Count_o;

  modport slave (
    input  Start_i, Redirect_i, Redirect_Target_i, Instruction_i, Ready_i,
    output Fetch_Address_o, Instruction_o, PC_o, PC_Plus4_o, Valid_o,
           Error_o, Fetch_Count_o
  );

  modport master (
    output Start_i, Redirect_i, Redirect_Target_i, Instruction_i, Ready_i,
    input  Fetch_Address_o, Instruction_o, PC_o, PC_Plus4_o, Valid_o,
           Error_o, Fetch_Count_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Presents the PC to program memory combinationally, captures the returned
// word into IF/ID when decode can take it, honours branch/jump redirects
// (flushing IF/ID) and halts with a sticky error on a misaligned target.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - instruction_fetch_if.slave: Start_i, Redirect_i,
//           Redirect_Target_i, Instruction_i, Ready_i in;
//           Fetch_Address_o, Instruction_o, PC_o, PC_Plus4_o, Valid_o,
//           Error_o, Fetch_Count_o out
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic target_aligned;
  logic redir_ok;
  logic redir_bad;
  logic load_en;

  // A redirect outranks both load and stall; a stall is simply the absence
  // of load_en while IF/ID is occupied.
  assign target_aligned = (bus.Redirect_Target_i[1:0] == 2'b00);
  assign redir_ok  = (state_q == FETCH) && bus.Redirect_i &&  target_aligned;
  assign redir_bad = (state_q == FETCH) && bus.Redirect_i && !target_aligned;
  assign load_en   = (state_q == FETCH) && !bus.Redirect_i
                     && (!valid_q || bus.Ready_i);

  // ---- state register / IF-ID register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start_i) state_d = FETCH;
      FETCH:   if (redir_bad)   state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // ---- datapath / output next values ----
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    error_d  = error_q | redir_bad;
    // The transfer counter sees the handshake even on a redirect edge.
    count_d  = count_q + DATA_WIDTH'(valid_q && bus.Ready_i);

    if (redir_ok) begin
      pc_d    = bus.Redirect_Target_i;
      valid_d = 1'b0;
    end else if (redir_bad) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      instr_d  = bus.Instruction_i;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + PC_STEP;
    end
  end

  assign bus.Fetch_Address_o = pc_q;
  assign bus.Instruction_o   = instr_q;
  assign bus.PC_o            = pc_out_q;
  assign bus.PC_Plus4_o      = pc_out_q + PC_STEP;
  assign bus.Valid_o         = valid_q;
  assign bus.Error_o         = error_q;
  assign bus.Fetch_Count_o   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program memory: the word at address A is its word index from RESET_PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    return off >> 2;
  endfunction

  assign bus.Instruction_i = mem_word(bus.Fetch_Address_o);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference ----------------
  // The model tracks what the outside world can observe: the address being
  // fetched, what sits in IF/ID, the sticky error and the transfer tally.
  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2;
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pcout, m_cnt;
  logic        m_valid, m_err;
  bit          model_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      model_live = 1;
      m_mode = M_IDLE; m_pc = RESET_PC; m_valid = 0; m_err = 0;
      m_cnt = 0; m_instr = 0; m_pcout = 0;
    end else if (model_live) begin
      bit handshake;
      handshake = m_valid && bus.Ready_i;
      if (handshake) m_cnt = m_cnt + 1;
      if (m_mode == M_IDLE) begin
        if (bus.Start_i) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (bus.Redirect_i) begin
          m_valid = 0;
          if (bus.Redirect_Target_i % 4 == 0) m_pc = bus.Redirect_Target_i;
          else begin m_mode = M_DEAD; m_err = 1; end
        end else if (!m_valid || handshake) begin
          m_instr = mem_word(m_pc);
          m_pcout = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 4;
        end
      end
    end
  end

  // Single compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (model_live) begin
      chk("fetch_addr", bus.Fetch_Address_o, m_pc);
      chk("valid",      {31'b0, bus.Valid_o}, {31'b0, m_valid});
      chk("error",      {31'b0, bus.Error_o}, {31'b0, m_err});
      chk("count",      bus.Fetch_Count_o, m_cnt);
      chk("instr",      bus.Instruction_o, m_instr);
      chk("pc_o",       bus.PC_o, m_pcout);
      chk("pc_plus4",   bus.PC_Plus4_o, m_pcout + 32'd4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus + literal pins ----------------
  initial begin
    logic [31:0] t;
    int r;
    reset = 1;
    bus.Start_i = 0; bus.Redirect_i = 0; bus.Redirect_Target_i = 0; bus.Ready_i = 1;
    step(); step();
    chk("rst_valid", {31'b0, bus.Valid_o}, 32'd0);
    chk("rst_count", bus.Fetch_Count_o, 32'd0);
    chk("rst_instr", bus.Instruction_o, 32'd0);
    chk("rst_pco",   bus.PC_o, 32'd0);
    reset = 0;
    step();
    chk("post_rst_addr", bus.Fetch_Address_o, 32'h0040_0000);

    // Start, streaming with Ready=1
    bus.Start_i = 1; step(); bus.Start_i = 0;
    chk("idle_to_fetch_valid", {31'b0, bus.Valid_o}, 32'd0);
    step();
    chk("w0_instr", bus.Instruction_o, 32'd0);
    chk("w0_pc",    bus.PC_o, 32'h0040_0000);
    chk("w0_valid", {31'b0, bus.Valid_o}, 32'd1);
    step();
    chk("w1_instr", bus.Instruction_o, 32'd1);
    chk("w1_pc",    bus.PC_o, 32'h0040_0004);
    chk("w1_count", bus.Fetch_Count_o, 32'd1);
    step();
    chk("w2_instr", bus.Instruction_o, 32'd2);
    chk("w2_count", bus.Fetch_Count_o, 32'd2);

    // Stall for three cycles
    bus.Ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", bus.Instruction_o, 32'd2);
      chk("stall_pc",    bus.PC_o, 32'h0040_0008);
      chk("stall_addr",  bus.Fetch_Address_o, 32'h0040_000C);
      chk("stall_count", bus.Fetch_Count_o, 32'd2);
    end
    bus.Ready_i = 1;
    step();
    chk("resume_instr", bus.Instruction_o, 32'd3);
    chk("resume_count", bus.Fetch_Count_o, 32'd3);

    // Aligned redirect with a handshake on the same edge
    bus.Redirect_i = 1; bus.Redirect_Target_i = 32'h0040_0040;
    step(); bus.Redirect_i = 0;
    chk("redir_valid", {31'b0, bus.Valid_o}, 32'd0);
    chk("redir_count", bus.Fetch_Count_o, 32'd4);
    step();
    chk("redir_pc",    bus.PC_o, 32'h0040_0040);
    chk("redir_instr", bus.Instruction_o, 32'd16);
    step();
    chk("redir_next",  bus.Instruction_o, 32'd17);

    // PC wrap
    bus.Redirect_i = 1; bus.Redirect_Target_i = 32'hFFFF_FFFC;
    step(); bus.Redirect_i = 0;
    step();
    chk("wrap_pc",     bus.PC_o, 32'hFFFF_FFFC);
    chk("wrap_plus4",  bus.PC_Plus4_o, 32'h0000_0000);
    chk("wrap_instr",  bus.Instruction_o, 32'h3FEF_FFFF);
    step();
    chk("wrap_pc0",    bus.PC_o, 32'h0000_0000);
    chk("wrap_err",    {31'b0, bus.Error_o}, 32'd0);
    chk("wrap_count",  bus.Fetch_Count_o, 32'd7);

    // Misaligned redirect -> halt
    bus.Redirect_i = 1; bus.Redirect_Target_i = 32'h0040_0042;
    step(); bus.Redirect_i = 0;
    chk("halt_err",   {31'b0, bus.Error_o}, 32'd1);
    chk("halt_valid", {31'b0, bus.Valid_o}, 32'd0);
    chk("halt_count", bus.Fetch_Count_o, 32'd8);
    chk("halt_addr",  bus.Fetch_Address_o, 32'h0000_0004);
    bus.Start_i = 1; bus.Redirect_i = 1; bus.Redirect_Target_i = 32'h0040_0000;
    step(); step();
    chk("halt_stuck_err",  {31'b0, bus.Error_o}, 32'd1);
    chk("halt_stuck_addr", bus.Fetch_Address_o, 32'h0000_0004);
    chk("halt_stuck_vld",  {31'b0, bus.Valid_o}, 32'd0);
    bus.Start_i = 0; bus.Redirect_i = 0;

    // Reset mid-stall with count 5
    reset = 1; step(); reset = 0; step();
    bus.Start_i = 1; step(); bus.Start_i = 0;
    step();
    for (int i = 0; i < 5; i++) step();
    bus.Ready_i = 0; step();
    chk("pre_rst_count", bus.Fetch_Count_o, 32'd5);
    reset = 1; bus.Ready_i = 1; bus.Redirect_i = 1;
    bus.Redirect_Target_i = 32'h0040_0040; bus.Start_i = 1;
    step();
    chk("mid_rst_count", bus.Fetch_Count_o, 32'd0);
    chk("mid_rst_valid", {31'b0, bus.Valid_o}, 32'd0);
    chk("mid_rst_addr",  bus.Fetch_Address_o, 32'h0040_0000);
    chk("mid_rst_pco",   bus.PC_o, 32'd0);
    chk("mid_rst_instr", bus.Instruction_o, 32'd0);
    reset = 0; bus.Redirect_i = 0; bus.Start_i = 0;

    // Randomized phase, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 249) == 0);
      bus.Start_i  = ($urandom_range(0, 7) == 0);
      bus.Redirect_i = ($urandom_range(0, 9) == 0);
      bus.Ready_i  = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 29);
      t = $urandom;
      if (r < 15) t = RESET_PC + {20'b0, t[11:0]};
      else if (r < 17) t = 32'hFFFF_FFF0 + {28'b0, t[3:0]};
      if (r != 0) t[1:0] = 2'b00;
      else if (t[1:0] == 2'b00) t[1:0] = 2'b10;
      bus.Redirect_Target_i = t;
      step();
    end
    reset = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
